// File: rtl/kyber_arith_pkg.sv
// Shared mod-q arithmetic types and constants for the Kyber coefficient datapath.
// The CONV_M/CONV_R states exist only when MONT_ACC_CONVERT_EN is defined.
package kyber_arith_pkg;

  localparam int MOD     = 3329;
  localparam int MOD_INV = 3327;
  localparam int R2_MOD  = 2385;
  localparam int WIDTH   = 12;

  typedef logic [WIDTH-1:0] coeff_t;

  typedef enum logic [2:0] {
    IDLE,
    ACC,
`ifdef MONT_ACC_CONVERT_EN
    CONV_M,
    CONV_R,
`endif
    HOLD
  } acc_state_e;

  // Both operands must already be in [0, q-1]; one conditional subtract suffices.
  function automatic coeff_t mod_add(coeff_t a, coeff_t b);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= (WIDTH+1)'(MOD)) ? coeff_t'(s - (WIDTH+1)'(MOD)) : coeff_t'(s);
  endfunction

endpackage

// File: rtl/mont_acc_reduce_if.sv
// Term input stream and packet result stream of the modular accumulator.
interface mont_acc_reduce_if #(
  parameter int WIDTH = 12,
  parameter int CW    = 9
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    out_count;
  logic             out_overrun;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_overrun
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_overrun
  );
endinterface

// File: rtl/mont_reduce_2stage.sv
// Two-stage registered Montgomery REDC: stage 1 latches m = a*(-q^-1) mod 2^12,
// stage 2 latches (a + m*q) >> 12 after one conditional subtract of q.
module mont_reduce_2stage #(
  parameter int MOD     = kyber_arith_pkg::MOD,
  parameter int MOD_INV = kyber_arith_pkg::MOD_INV
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  kyber_arith_pkg::coeff_t a,
  output logic                    valid,
  output kyber_arith_pkg::coeff_t res
);
  import kyber_arith_pkg::*;

  localparam int     TW    = 2*WIDTH + 1;
  localparam coeff_t MOD_C = coeff_t'(MOD);
  localparam coeff_t INV_C = coeff_t'(MOD_INV);

  coeff_t           a_q, m_q, m_next, res_next;
  logic [TW-1:0]    t_full;
  logic [WIDTH:0]   t;
  logic             busy;

  assign m_next   = coeff_t'(a * INV_C);
  assign t_full   = TW'(a_q) + TW'(m_q) * TW'(MOD_C);
  assign t        = (WIDTH+1)'(t_full >> WIDTH);
  assign res_next = (t >= (WIDTH+1)'(MOD)) ? coeff_t'(t - (WIDTH+1)'(MOD)) : coeff_t'(t);

  // valid marks the cycle whose closing edge loads res.
  assign valid = busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      m_q  <= '0;
      busy <= 1'b0;
      res  <= '0;
    end else begin
      busy <= start;
      if (start) begin
        a_q <= a;
        m_q <= m_next;
      end
      if (busy) res <= res_next;
    end
  end

endmodule

// File: rtl/mont_acc_reduce.sv
// Streaming mod-q accumulator for Montgomery-domain products, one result per packet.
// Define MONT_ACC_CONVERT_EN to convert each packet sum back to the normal domain.
//
// state  | meaning
// IDLE   | waiting for first term; first term overwrites acc
// ACC    | accumulating terms of the current packet
// CONV_M | REDC stage 1 (m) running on final acc
// CONV_R | REDC stage 2 (t, conditional subtract) running
// HOLD   | result presented until out_ready
module mont_acc_reduce #(
  parameter int MOD       = kyber_arith_pkg::MOD,
`ifdef MONT_ACC_CONVERT_EN
  parameter int MOD_INV   = kyber_arith_pkg::MOD_INV,
`endif
  parameter int WIDTH     = kyber_arith_pkg::WIDTH,
  parameter int TERMS_MAX = 256,
  parameter int CW        = $clog2(TERMS_MAX + 1)
) (
  input logic              clk,
  input logic              rst_n,
  mont_acc_reduce_if.slave bus
);
  import kyber_arith_pkg::*;

  localparam logic [WIDTH-1:0] MOD_C   = WIDTH'(MOD);
  localparam logic [CW-1:0]    TERMS_C = CW'(TERMS_MAX);

  acc_state_e       state;
  logic [WIDTH-1:0] acc, x_norm, acc_sum;
  logic [CW-1:0]    cnt, cnt_next, out_count_q;
  logic             in_ready_q, out_valid_q, out_overrun_q;
  logic             take, pkt_end;

  assign take     = bus.in_valid && in_ready_q;
  assign x_norm   = (bus.in_data >= MOD_C) ? bus.in_data - MOD_C : bus.in_data;
  assign acc_sum  = (state == IDLE) ? x_norm : mod_add(acc, x_norm);
  assign cnt_next = (state == IDLE) ? CW'(1) : cnt + CW'(1);
  assign pkt_end  = bus.in_last || (cnt_next == TERMS_C);

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_count   = out_count_q;
  assign bus.out_overrun = out_overrun_q;

`ifdef MONT_ACC_CONVERT_EN
  logic             conv_start, conv_done;
  logic [WIDTH-1:0] conv_res;

  assign conv_start = (state == CONV_M);

  mont_reduce_2stage #(
    .MOD     (MOD),
    .MOD_INV (MOD_INV)
  ) u_reduce (
    .clk   (clk),
    .rst_n (rst_n),
    .start (conv_start),
    .a     (acc),
    .valid (conv_done),
    .res   (conv_res)
  );

  // The REDC result register holds until the next packet, so it drives out_data directly.
  assign bus.out_data = conv_res;
`else
  logic [WIDTH-1:0] out_data_q;

  assign bus.out_data = out_data_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      acc           <= '0;
      cnt           <= '0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      out_count_q   <= '0;
      out_overrun_q <= 1'b0;
`ifndef MONT_ACC_CONVERT_EN
      out_data_q    <= '0;
`endif
    end else begin
      case (state)
        IDLE, ACC: begin
          if (take) begin
            acc   <= acc_sum;
            cnt   <= cnt_next;
            state <= ACC;
            if (pkt_end) begin
              out_count_q   <= cnt_next;
              out_overrun_q <= !bus.in_last;
              in_ready_q    <= 1'b0;
`ifdef MONT_ACC_CONVERT_EN
              state         <= CONV_M;
`else
              state         <= HOLD;
              out_valid_q   <= 1'b1;
              out_data_q    <= acc_sum;
`endif
            end
          end
        end
`ifdef MONT_ACC_CONVERT_EN
        CONV_M: state <= CONV_R;
        CONV_R: begin
          if (conv_done) begin
            state       <= HOLD;
            out_valid_q <= 1'b1;
          end
        end
`endif
        HOLD: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_acc_reduce.sv
// Directed bench for mont_acc_reduce with TERMS_MAX reduced to 4; expectations
// follow MONT_ACC_CONVERT_EN (normal-domain result, 3-cycle latency) or not.
module tb_mont_acc_reduce;

  localparam int TM  = 4;
  localparam int CWB = 3;
`ifdef MONT_ACC_CONVERT_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  mont_acc_reduce_if #(.WIDTH(12), .CW(CWB)) bus ();

  mont_acc_reduce #(.TERMS_MAX(TM), .CW(CWB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n;
    int d[4];
    bit last;
    int exp_conv;
    int exp_raw;
    int exp_cnt;
    bit exp_ovr;
  } vec_t;

  vec_t vecs[7];
  int   passed = 0;
  int   total  = 0;

  function automatic int expd(input int conv, input int raw);
`ifdef MONT_ACC_CONVERT_EN
    return conv;
`else
    return raw;
`endif
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, " out_valid"},   int'(bus.out_valid),   0);
    check({tag, " out_data"},    int'(bus.out_data),    0);
    check({tag, " out_count"},   int'(bus.out_count),   0);
    check({tag, " out_overrun"}, int'(bus.out_overrun), 0);
    check({tag, " in_ready"},    int'(bus.in_ready),    1);
  endtask

  task automatic send_terms(input vec_t v, input string tag);
    for (int i = 0; i < v.n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 12'(v.d[i]);
      bus.in_last  = v.last && (i == v.n - 1);
      check($sformatf("%s in_ready term%0d", tag, i), int'(bus.in_ready), 1);
      step();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = '0;
    check({tag, " in_ready after end"}, int'(bus.in_ready), 0);
  endtask

  // Called right after the accepting edge of the final term.
  task automatic wait_valid(input string tag);
    int cyc = 1;
    while (!bus.out_valid && cyc < 20) begin
      step();
      cyc++;
    end
    check({tag, " latency"}, cyc, LAT);
  endtask

  task automatic check_result(input string tag, input int d, input int c, input int o);
    check({tag, " out_data"},    int'(bus.out_data),    d);
    check({tag, " out_count"},   int'(bus.out_count),   c);
    check({tag, " out_overrun"}, int'(bus.out_overrun), o);
  endtask

  task automatic handshake(input string tag);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check({tag, " out_valid after hs"}, int'(bus.out_valid), 0);
    check({tag, " in_ready after hs"},  int'(bus.in_ready),  1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    send_terms(v, tag);
    wait_valid(tag);
    check_result(tag, expd(v.exp_conv, v.exp_raw), v.exp_cnt, int'(v.exp_ovr));
    handshake(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t hv;
    vec_t rv;
    vec_t sv;

    // n, terms, last, expected (converted), expected (Montgomery), count, overrun
    vecs[0] = '{2, '{767, 767, 0, 0},     1'b1, 2,    1534, 2, 1'b0};
    vecs[1] = '{2, '{2562, 767, 0, 0},    1'b1, 0,    0,    2, 1'b0};
    vecs[2] = '{1, '{3329, 0, 0, 0},      1'b1, 0,    0,    1, 1'b0};
    vecs[3] = '{4, '{767, 767, 767, 767}, 1'b0, 4,    3068, 4, 1'b1};
    vecs[4] = '{2, '{4095, 1, 0, 0},      1'b1, 1,    767,  2, 1'b0};
    vecs[5] = '{3, '{3328, 3328, 3, 0},   1'b1, 2704, 1,    3, 1'b0};
    vecs[6] = '{4, '{1, 1, 1, 1},         1'b1, 829,  4,    4, 1'b0};
    hv      = '{2, '{767, 767, 0, 0},     1'b1, 2,    1534, 2, 1'b0};
    rv      = '{2, '{767, 767, 0, 0},     1'b1, 2,    1534, 2, 1'b0};
    sv      = '{1, '{767, 0, 0, 0},       1'b1, 1,    767,  1, 1'b0};

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    #12;
    check_reset("reset");
    rst_n = 1'b1;
    step();

    for (int k = 0; k < 7; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

    // Stall in HOLD while offering a term that must not be taken.
    send_terms(hv, "hold");
    wait_valid("hold");
    bus.in_valid = 1'b1;
    bus.in_data  = 12'd100;
    bus.in_last  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("hold data c%0d", i),  int'(bus.out_data),  expd(2, 1534));
      check($sformatf("hold ready c%0d", i), int'(bus.in_ready),  0);
      check($sformatf("hold valid c%0d", i), int'(bus.out_valid), 1);
    end
    check("hold count", int'(bus.out_count), 2);
    bus.in_data   = 12'd767;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("hold release in_ready",  int'(bus.in_ready),  1);
    check("hold release out_valid", int'(bus.out_valid), 0);
    step();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = '0;
    wait_valid("post-hold");
    check_result("post-hold", expd(1, 767), 1, 0);
    handshake("post-hold");

    // Asynchronous reset one cycle after the last accept (CONV_R when converting).
    send_terms(rv, "rst");
    step();
    #2 rst_n = 1'b0;
    #1 check_reset("async rst");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run_vec(sv, "after rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
